// File: rtl/imm_extend_pipe_if.sv
// Request/result bundle for imm_extend_pipe. The slave side is the
// decoder and the master side is whoever feeds it and drains it.
interface imm_extend_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, imm_ext, out_tag, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, imm_ext, out_tag, illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// RISC-V immediate decode/extend. Decoding happens on accept; a 2-entry
// FIFO of decoded results drives the outputs straight from registers.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_extend_pipe_if.slave bus
);
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           dec;
  entry_t           head;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             push, pop;
  logic [24:0]      ins;

  // ins holds instruction bits [31:7]: instruction bit n lives at ins[n-7]
  assign ins = bus.instr;

  always_comb begin
    dec     = '0;
    dec.tag = bus.in_tag;
    case (bus.imm_src)
      3'b000:  dec.imm = {{(XLEN-12){ins[24]}}, ins[24:13]};
      3'b001:  dec.imm = {{(XLEN-12){ins[24]}}, ins[24:18], ins[4:0]};
      3'b010:  dec.imm = {{(XLEN-12){ins[24]}}, ins[0], ins[23:18], ins[4:1], 1'b0};
      3'b011:  dec.imm = {{(XLEN-20){ins[24]}}, ins[12:5], ins[13], ins[23:14], 1'b0};
      3'b100:  dec.imm = {{(XLEN-31){ins[24]}}, ins[23:5], 12'b0};
      3'b101:  dec.imm = {{(XLEN-5){1'b0}}, ins[12:8]};
      default: dec.ill = 1'b1;
    endcase
  end

  assign bus.in_ready  = (cnt_q != 2'd2);
  assign bus.out_valid = (cnt_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    ill_cnt_d = ill_cnt_q;
    if (push && dec.ill && (ill_cnt_q != {CNT_W{1'b1}}))
      ill_cnt_d = ill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      ill_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= dec;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.imm_ext     = head.imm;
  assign bus.out_tag     = head.tag;
  assign bus.illegal     = head.ill;
  assign bus.illegal_cnt = ill_cnt_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 32-bit instance and a 64-bit instance with a
// 2-bit illegal counter, each checked by an accept/output scoreboard.
module tb_imm_extend_pipe;
  logic clk;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  typedef struct { logic [63:0] imm; logic ill; logic [4:0] tag; } exp_t;
  exp_t q32[$];
  exp_t q64[$];

  imm_extend_pipe_if #(.XLEN(32), .TAG_W(5), .CNT_W(16)) b32 ();
  imm_extend_pipe_if #(.XLEN(64), .TAG_W(5), .CNT_W(2))  b64 ();

  imm_extend_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) u32 (.clk(clk), .reset_n(rst_n), .bus(b32));
  imm_extend_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2))  u64 (.clk(clk), .reset_n(rst_n), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] w, input logic [2:0] s,
                                 input logic [4:0] t, input bit x64);
    exp_t e;
    logic signed [63:0] v;
    e.ill = 1'b0;
    e.tag = t;
    case (s)
      3'd0:    v = 64'($signed(w[31:20]));
      3'd1:    v = 64'($signed({w[31:25], w[11:7]}));
      3'd2:    v = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3'd3:    v = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      3'd4:    v = 64'($signed({w[31:12], 12'd0}));
      3'd5:    v = 64'(w[19:15]);
      default: begin v = '0; e.ill = 1'b1; end
    endcase
    e.imm = x64 ? v : {32'd0, v[31:0]};
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv32(input logic v, input logic [31:0] w, input logic [2:0] s, input logic [4:0] t);
    b32.in_valid = v; b32.instr = w[31:7]; b32.imm_src = s; b32.in_tag = t;
  endtask

  task automatic drv64(input logic v, input logic [31:0] w, input logic [2:0] s, input logic [4:0] t);
    b64.in_valid = v; b64.instr = w[31:7]; b64.imm_src = s; b64.in_tag = t;
  endtask

  task automatic mon32();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b32.out_valid && b32.out_ready) begin
          vecs++;
          if (q32.size() == 0) begin
            errs++; $display("FAIL mon32 spurious output: got tag %0d expected no output", b32.out_tag);
          end else begin
            e = q32.pop_front();
            if (b32.imm_ext !== e.imm[31:0] || b32.illegal !== e.ill || b32.out_tag !== e.tag) begin
              errs++;
              $display("FAIL mon32 result: got %h/%b/%0d expected %h/%b/%0d",
                       b32.imm_ext, b32.illegal, b32.out_tag, e.imm[31:0], e.ill, e.tag);
            end
          end
        end
        if (b32.in_valid && b32.in_ready)
          q32.push_back(model({b32.instr, 7'd0}, b32.imm_src, b32.in_tag, 1'b0));
      end
    end
  endtask

  task automatic mon64();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b64.out_valid && b64.out_ready) begin
          vecs++;
          if (q64.size() == 0) begin
            errs++; $display("FAIL mon64 spurious output: got tag %0d expected no output", b64.out_tag);
          end else begin
            e = q64.pop_front();
            if (b64.imm_ext !== e.imm || b64.illegal !== e.ill || b64.out_tag !== e.tag) begin
              errs++;
              $display("FAIL mon64 result: got %h/%b/%0d expected %h/%b/%0d",
                       b64.imm_ext, b64.illegal, b64.out_tag, e.imm, e.ill, e.tag);
            end
          end
        end
        if (b64.in_valid && b64.in_ready)
          q64.push_back(model({b64.instr, 7'd0}, b64.imm_src, b64.in_tag, 1'b1));
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    exp_t e;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    drv32(1'b1, 32'hFFFFFFFF, 3'b111, 5'd31);
    drv64(1'b1, 32'hFFFFFFFF, 3'b111, 5'd31);
    b32.out_ready = 1'b1;
    b64.out_ready = 1'b1;
    #2;
    vecs++; if (b32.out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b expected 0", b32.out_valid); end
    vecs++; if (b32.in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready: got %b expected 1", b32.in_ready); end
    vecs++; if (b32.imm_ext !== 32'd0 || b32.out_tag !== 5'd0 || b32.illegal !== 1'b0) begin
      errs++; $display("FAIL reset outputs: got %h/%0d/%b expected 0/0/0", b32.imm_ext, b32.out_tag, b32.illegal); end
    vecs++; if (b32.illegal_cnt !== 16'd0 || b64.illegal_cnt !== 2'd0) begin
      errs++; $display("FAIL reset illegal_cnt: got %0d/%0d expected 0/0", b32.illegal_cnt, b64.illegal_cnt); end
    step(); step();
    vecs++; if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0 || b64.illegal_cnt !== 2'd0) begin
      errs++; $display("FAIL reset ignores inputs: got %b/%b/%0d expected 0/0/0", b32.out_valid, b64.out_valid, b64.illegal_cnt); end
    rst_n = 1'b1;
    w = 32'h80000F63;
    e = model(w, 3'd2, 5'd7, 1'b0);
    drv32(1'b1, w, 3'd2, 5'd7);
    drv64(1'b0, 32'd0, 3'd0, 5'd0);
    step();
    vecs++; if (b32.out_valid !== 1'b1 || b32.imm_ext !== e.imm[31:0] || b32.out_tag !== 5'd7) begin
      errs++; $display("FAIL first accept: got %b/%h/%0d expected 1/%h/7", b32.out_valid, b32.imm_ext, b32.out_tag, e.imm[31:0]); end
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    step(); step();
  endtask

  task automatic test_spec_vectors();
    logic [31:0] ws [4] = '{32'hFFF00093, 32'hFE20AE23, 32'hFFDFF06F, 32'h123452B7};
    logic [2:0]  ss [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000};
    b32.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv32(1'b1, ws[k], ss[k], 5'(k + 1));
      vecs++; if (b32.in_ready !== 1'b1) begin errs++; $display("FAIL vec%0d in_ready: got %b expected 1", k, b32.in_ready); end
      step();
      vecs++; if (b32.out_valid !== 1'b1 || b32.imm_ext !== ex[k] || b32.out_tag !== 5'(k + 1)) begin
        errs++; $display("FAIL vec%0d: got %b/%h/%0d expected 1/%h/%0d", k, b32.out_valid, b32.imm_ext, b32.out_tag, ex[k], k + 1); end
    end
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    vecs++; if (b32.illegal_cnt !== 16'd0) begin errs++; $display("FAIL illegal_cnt start: got %0d expected 0", b32.illegal_cnt); end
    for (int k = 0; k < 5; k++) begin
      w = $urandom();
      drv32(k < 3, w, 3'b111, 5'(10 + k));
      drv64(1'b1, w, (k == 1) ? 3'b110 : 3'b111, 5'(10 + k));
      step();
      if (k < 3) begin
        vecs++; if (b32.out_valid !== 1'b1 || b32.illegal !== 1'b1 || b32.imm_ext !== 32'd0) begin
          errs++; $display("FAIL illegal32 #%0d: got %b/%b/%h expected 1/1/0", k, b32.out_valid, b32.illegal, b32.imm_ext); end
      end
      vecs++; if (b64.illegal !== 1'b1 || b64.imm_ext !== 64'd0) begin
        errs++; $display("FAIL illegal64 #%0d: got %b/%h expected 1/0", k, b64.illegal, b64.imm_ext); end
      vecs++; if (b64.illegal_cnt !== ((k >= 2) ? 2'd3 : 2'(k + 1))) begin
        errs++; $display("FAIL illegal_cnt sat #%0d: got %0d expected %0d", k, b64.illegal_cnt, (k >= 2) ? 3 : k + 1); end
    end
    vecs++; if (b32.illegal_cnt !== 16'd3) begin errs++; $display("FAIL illegal_cnt32: got %0d expected 3", b32.illegal_cnt); end
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    drv64(1'b0, 32'd0, 3'd0, 5'd0);
    step();
  endtask

  task automatic test_xlen64();
    b64.out_ready = 1'b1;
    drv64(1'b1, 32'h800002B7, 3'd4, 5'd1);
    step();
    vecs++; if (b64.imm_ext !== 64'hFFFFFFFF80000000 || b64.out_tag !== 5'd1 || b64.illegal !== 1'b0) begin
      errs++; $display("FAIL u64 U-type: got %h/%0d/%b expected ffffffff80000000/1/0", b64.imm_ext, b64.out_tag, b64.illegal); end
    drv64(1'b1, 32'hFFFFF073, 3'd5, 5'd2);
    step();
    vecs++; if (b64.imm_ext !== 64'h1F || b64.out_tag !== 5'd2) begin
      errs++; $display("FAIL u64 Z-type: got %h/%0d expected 1f/2", b64.imm_ext, b64.out_tag); end
    drv64(1'b1, 32'hFFF00093, 3'd0, 5'd3);
    step();
    vecs++; if (b64.imm_ext !== 64'hFFFFFFFFFFFFFFFF) begin
      errs++; $display("FAIL u64 I-type: got %h expected ffffffffffffffff", b64.imm_ext); end
    drv64(1'b0, 32'd0, 3'd0, 5'd0);
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] wa;
    exp_t ea;
    wa = $urandom();
    ea = model(wa, 3'd1, 5'd21, 1'b0);
    b32.out_ready = 1'b0;
    drv32(1'b1, wa, 3'd1, 5'd21);
    step();
    drv32(1'b1, $urandom(), 3'd3, 5'd22);
    step();
    drv32(1'b1, $urandom(), 3'd4, 5'd23);
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1 || b32.imm_ext !== ea.imm[31:0] || b32.out_tag !== 5'd21) begin
        errs++; $display("FAIL backpressure hold %0d: got rdy=%b vld=%b %h/%0d expected 0/1 %h/21",
                         k, b32.in_ready, b32.out_valid, b32.imm_ext, b32.out_tag, ea.imm[31:0]); end
    end
    b32.out_ready = 1'b1;
    step();
    vecs++; if (b32.out_tag !== 5'd22 || b32.in_ready !== 1'b1) begin
      errs++; $display("FAIL pop at full: got tag %0d rdy %b expected 22/1", b32.out_tag, b32.in_ready); end
    step();
    vecs++; if (b32.out_tag !== 5'd23 || b32.out_valid !== 1'b1) begin
      errs++; $display("FAIL push+pop: got tag %0d vld %b expected 23/1", b32.out_tag, b32.out_valid); end
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    step();
    vecs++; if (b32.out_valid !== 1'b0) begin errs++; $display("FAIL drain empty: got %b expected 0", b32.out_valid); end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 80; k++) begin
      drv32($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)), 5'($urandom()));
      drv64($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)), 5'($urandom()));
      b32.out_ready = ($urandom_range(0, 3) != 0);
      b64.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    drv64(1'b0, 32'd0, 3'd0, 5'd0);
    b32.out_ready = 1'b1;
    b64.out_ready = 1'b1;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 20) begin step(); n++; end
    vecs++; if (q32.size() != 0 || q64.size() != 0 || b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
      errs++; $display("FAIL random drain: got pending %0d/%0d expected 0/0", q32.size(), q64.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    exp_t e;
    b32.out_ready = 1'b0;
    drv32(1'b1, $urandom(), 3'd0, 5'd1);
    step();
    drv32(1'b1, $urandom(), 3'd1, 5'd2);
    step();
    vecs++; if (b32.in_ready !== 1'b0) begin errs++; $display("FAIL mid-reset full: got rdy %b expected 0", b32.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.imm_ext !== 32'd0 || b32.illegal_cnt !== 16'd0) begin
      errs++; $display("FAIL async reset: got vld=%b rdy=%b imm=%h cnt=%0d expected 0/1/0/0",
                       b32.out_valid, b32.in_ready, b32.imm_ext, b32.illegal_cnt); end
    q32.delete();
    q64.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    w = 32'hABCDE2B7;
    e = model(w, 3'd4, 5'd9, 1'b0);
    b32.out_ready = 1'b1;
    drv32(1'b1, w, 3'd4, 5'd9);
    step();
    vecs++; if (b32.out_valid !== 1'b1 || b32.imm_ext !== e.imm[31:0] || b32.out_tag !== 5'd9) begin
      errs++; $display("FAIL post-reset request: got %b/%h/%0d expected 1/%h/9", b32.out_valid, b32.imm_ext, b32.out_tag, e.imm[31:0]); end
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    step();
    vecs++; if (b32.out_valid !== 1'b0) begin errs++; $display("FAIL stale after reset: got vld %b expected 0", b32.out_valid); end
  endtask

  initial begin
    drv32(1'b0, 32'd0, 3'd0, 5'd0);
    drv64(1'b0, 32'd0, 3'd0, 5'd0);
    b32.out_ready = 1'b1;
    b64.out_ready = 1'b1;
    fork
      mon32();
      mon64();
    join_none
    test_reset();
    test_spec_vectors();
    test_illegal();
    test_xlen64();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the immediate output width; only 32 and 64 are legal, and any other value SHALL stop elaboration.
REQ-002 Parameter TAG_W, default 5, SHALL set the width of the sideband tag that travels with each request.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the illegal-encoding counter.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 instr  input  25  instruction bits [31:7].
REQ-009 imm_src  input  3  immediate format select.
REQ-010 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 imm_ext  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAG_W  tag belonging to imm_ext.
REQ-015 illegal  output  1  imm_src of this result was unsupported.
REQ-016 illegal_cnt  output  CNT_W  saturating count of accepted illegal requests.

Function
REQ-017 Decoding, with s = instr[31] and all results extended to XLEN:
- 000 I: sign-extend instr[31:20].
- 001 S: sign-extend {instr[31:25], instr[11:7]}.
- 010 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- 011 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN = 64.
- 101 Z: zero-extend instr[19:15] (CSR immediate).
REQ-018 imm_src 110 or 111 SHALL produce imm_ext = 0 and illegal = 1; every legal code SHALL produce illegal = 0.
REQ-019 Decoding SHALL happen at accept time; the buffer SHALL store the decoded {imm_ext, illegal, tag} and never the raw instruction.
REQ-020 Buffering and handshake:
- A 2-entry FIFO holds results, with occupancy count 0..2.
- A request is accepted when in_valid && in_ready.
- A result is popped when out_valid && out_ready.
REQ-021 in_ready SHALL equal (count < 2) and SHALL be driven only from registers, never from out_ready.
REQ-022 out_valid SHALL equal (count > 0); imm_ext, out_tag and illegal SHALL come from the head entry.
REQ-023 Latency SHALL be one cycle: a request accepted at edge N is visible at the output from edge N onward, i.e. in cycle N+1; there is no combinational path from input to output.
REQ-024 Throughput SHALL be one request per cycle while out_ready is held high.
REQ-025 Output stability: while out_valid && !out_ready, imm_ext, out_tag and illegal SHALL hold their values.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-027 At count = 2 no push can occur; a pop at count = 2 SHALL set count = 1, with in_ready rising the following cycle.
REQ-028 Results SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-029 illegal_cnt SHALL increment by 1 on each accepted request whose imm_src is illegal, and SHALL saturate at all-ones without wrapping.
REQ-030 in_valid, out_ready and the data inputs SHALL be ignored while reset_n = 0.

Reset
REQ-031 reset_n = 0 SHALL immediately, without a clock edge, force:
- count = 0, out_valid = 0, in_ready = 1
- imm_ext = 0, out_tag = 0, illegal = 0
- illegal_cnt = 0
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-033 The first accept SHALL be possible at the first rising edge after reset_n deasserts.

Verification
REQ-034 XLEN = 32, out_ready = 1; instructions 0xFFF00093 (I), 0xFE20AE23 (S), 0xFFDFF06F (J), 0x123452B7 (U) sent on consecutive cycles -> imm_ext = 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFFC, 0x12345000 on consecutive cycles, each one cycle after its accept, tags preserved.
REQ-035 XLEN = 64; U-type 0x800002B7 -> imm_ext = 0xFFFFFFFF80000000. Z-type with instr[19:15] = 5'b11111 -> imm_ext = 0x1F.
REQ-036 Backpressure: out_ready = 0 with 3 requests offered -> first 2 accepted, then in_ready = 0, head output stable. out_ready = 1 -> outputs in order A, B, then C accepted; no loss.
REQ-037 imm_src = 3'b111 three times -> imm_ext = 0, illegal = 1 on each, illegal_cnt = 3. With CNT_W = 2 and 5 illegal requests -> illegal_cnt stays at 3.
REQ-038 reset_n pulsed low while count = 2 -> out_valid = 0 and in_ready = 1 with no clock edge needed; after release, a new request is output correctly with no stale data.
